omsp_sha512_msg_packer: RTL and testbench

Message front end for the SHA-512 attestation/hash path. It accepts the 16-bit word stream from the hash control FSM and packs it big-endian into 64-bit message words for the SHA-512 compression core. It generates FIPS 180-4 padding and the length field. After compression it captures the 512-bit digest and serves it back to the control FSM 16 bits per cycle.

---
 rtl/omsp_sha512_msg_packer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_omsp_sha512_msg_packer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/omsp_sha512_msg_packer.sv
// rtl/omsp_sha512_msg_packer.sv - SHA-512 message packer, padder and digest reader
// Optional byte-granular input: OMSP_SHA512_BYTE_INPUT_EN

module omsp_sha512_msg_packer #(
    parameter int LEN_W    = 32,
    parameter int READ_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   cmd_in,
    input  logic [15:0]  data,
`ifdef OMSP_SHA512_BYTE_INPUT_EN
    input  logic         data_size,
`endif
    output logic         ready_for_data,
    output logic         busy,
    output logic [15:0]  hash,
    output logic         hash_valid,
    output logic [63:0]  core_word,
    output logic         core_valid,
    input  logic         core_ready,
    output logic         core_first,
    output logic         core_last,
    input  logic [511:0] core_digest,
    input  logic         core_done
);

`ifdef OMSP_SHA512_BYTE_INPUT_EN
    localparam int PW = 3;
`else
    localparam int PW = 2;
`endif
    localparam int LAT_W = (READ_LAT > 2) ? $clog2(READ_LAT) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_ABSORB, S_PAD, S_ZERO, S_LEN_HI, S_LEN_LO,
        S_WAIT_DIGEST, S_DIGEST, S_READ
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [63:0]        r_acc, w_acc_nxt;
    logic [PW-1:0]      r_ptr, w_ptr_nxt;
    logic [LEN_W-1:0]   r_len, w_len_nxt;
    logic [3:0]         r_widx;
    logic               r_first_sent;
    logic [63:0]        r_core_word;
    logic               r_core_valid, r_core_first, r_core_last;
    logic [511:0]       r_digest;
    logic [4:0]         r_ridx;
    logic [LAT_W-1:0]   r_lat;
    logic               r_hash_valid;
    logic [15:0]        r_hash;

    logic               w_hs, w_slot_free, w_stall, w_in_absorb, w_accept, w_start_read;
    logic [3:0]         w_load_idx, w_next_idx;
    logic               w_load, w_load_last;
    logic [63:0]        w_load_word, w_pad_word;
    logic [5:0]         w_used_bits, w_slot_base;
    logic [127:0]       w_len_field;
    logic [4:0]         w_ridx_nxt;
    logic [8:0]         w_hash_base;

    assign w_hs         = r_core_valid && core_ready;
    assign w_slot_free  = !r_core_valid || core_ready;
    assign w_stall      = r_core_valid && !core_ready;
    assign w_in_absorb  = (r_state == S_IDLE) || (r_state == S_ABSORB);
    // Index of the word that a load this cycle would occupy in the block.
    assign w_load_idx   = r_widx + {3'b000, r_core_valid};
    assign w_next_idx   = w_load_idx + 4'd1;
    assign w_len_field  = {{(128-LEN_W){1'b0}}, r_len};
    assign w_start_read = (r_state == S_DIGEST) && (cmd_in == 2'b01);
    assign w_ridx_nxt   = r_ridx + 5'd1;
    assign w_hash_base  = {~w_ridx_nxt, 4'b0000};

`ifdef OMSP_SHA512_BYTE_INPUT_EN
    logic [5:0] w_pair_base;
    assign w_used_bits = {r_ptr, 3'b000};
    assign w_slot_base = {~r_ptr, 3'b000};
    assign w_pair_base = w_slot_base - 6'd8;
    assign w_pad_word  = (r_acc & ~(64'hFFFF_FFFF_FFFF_FFFF >> w_used_bits)) | (64'h80 << w_slot_base);
    assign ready_for_data = w_in_absorb &&
        !(w_stall && ((r_ptr == 3'd7) || ((r_ptr == 3'd6) && data_size)));
`else
    assign w_used_bits = {r_ptr, 4'b0000};
    assign w_slot_base = {~r_ptr, 4'b0000};
    assign w_pad_word  = (r_acc & ~(64'hFFFF_FFFF_FFFF_FFFF >> w_used_bits)) | (64'h8000 << w_slot_base);
    assign ready_for_data = w_in_absorb && !(w_stall && (r_ptr == 2'd3));
`endif

    assign w_accept = (cmd_in == 2'b10) && ready_for_data;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_ptr_nxt   = r_ptr;
        w_len_nxt   = r_len;
        w_load      = 1'b0;
        w_load_word = '0;
        w_load_last = 1'b0;
        case (r_state)
            S_IDLE, S_ABSORB: begin
                if (cmd_in == 2'b11) begin
                    w_state_nxt = S_PAD;
                end else if (w_accept) begin
                    w_state_nxt = S_ABSORB;
`ifdef OMSP_SHA512_BYTE_INPUT_EN
                    if (!data_size) begin
                        w_acc_nxt[w_slot_base +: 8] = data[7:0];
                        w_len_nxt = r_len + LEN_W'(8);
                        w_ptr_nxt = r_ptr + 3'd1;
                        if (r_ptr == 3'd7) begin
                            w_load      = 1'b1;
                            w_load_word = w_acc_nxt;
                        end
                    end else if (r_ptr == 3'd7) begin
                        // Odd-offset halfword: high byte closes this word, low byte opens the next.
                        w_acc_nxt[7:0] = data[15:8];
                        w_load         = 1'b1;
                        w_load_word    = w_acc_nxt;
                        w_acc_nxt[63:56] = data[7:0];
                        w_len_nxt = r_len + LEN_W'(16);
                        w_ptr_nxt = 3'd1;
                    end else begin
                        w_acc_nxt[w_pair_base +: 16] = data;
                        w_len_nxt = r_len + LEN_W'(16);
                        w_ptr_nxt = r_ptr + 3'd2;
                        if (r_ptr == 3'd6) begin
                            w_load      = 1'b1;
                            w_load_word = w_acc_nxt;
                        end
                    end
`else
                    w_acc_nxt[w_slot_base +: 16] = data;
                    w_len_nxt = r_len + LEN_W'(16);
                    w_ptr_nxt = r_ptr + 2'd1;
                    if (r_ptr == 2'd3) begin
                        w_load      = 1'b1;
                        w_load_word = w_acc_nxt;
                    end
`endif
                end
            end
            S_PAD: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_load_word = w_pad_word;
                    w_state_nxt = (w_next_idx == 4'd14) ? S_LEN_HI : S_ZERO;
                end
            end
            S_ZERO: begin
                if (w_slot_free) begin
                    w_load = 1'b1;
                    if (w_next_idx == 4'd14) w_state_nxt = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_load_word = w_len_field[127:64];
                    w_state_nxt = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (!r_core_last && w_slot_free) begin
                    w_load      = 1'b1;
                    w_load_word = w_len_field[63:0];
                    w_load_last = 1'b1;
                end else if (r_core_last && w_hs) begin
                    w_state_nxt = S_WAIT_DIGEST;
                end
            end
            S_WAIT_DIGEST: if (core_done) w_state_nxt = S_DIGEST;
            S_DIGEST:      if (w_start_read) w_state_nxt = S_READ;
            S_READ:        if (r_hash_valid && (r_ridx == 5'd31)) w_state_nxt = S_IDLE;
            default:       w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc        <= '0;
            r_ptr        <= '0;
            r_len        <= '0;
            r_widx       <= '0;
            r_first_sent <= 1'b0;
            r_core_word  <= '0;
            r_core_valid <= 1'b0;
            r_core_first <= 1'b0;
            r_core_last  <= 1'b0;
            r_digest     <= '0;
            r_ridx       <= '0;
            r_lat        <= '0;
            r_hash_valid <= 1'b0;
            r_hash       <= '0;
        end else begin
            r_acc <= w_acc_nxt;
            r_ptr <= w_ptr_nxt;
            r_len <= w_len_nxt;
            if (w_hs) r_widx <= r_widx + 4'd1;

            if (w_load) begin
                r_core_word  <= w_load_word;
                r_core_valid <= 1'b1;
                r_core_first <= !r_first_sent;
                r_core_last  <= w_load_last;
                r_first_sent <= 1'b1;
            end else if (w_hs) begin
                r_core_valid <= 1'b0;
                r_core_first <= 1'b0;
                r_core_last  <= 1'b0;
            end

            if ((r_state == S_WAIT_DIGEST) && core_done) r_digest <= core_digest;

            if (w_start_read) begin
                r_ridx <= '0;
                if (READ_LAT <= 1) begin
                    r_hash_valid <= 1'b1;
                    r_hash       <= r_digest[511:496];
                end else begin
                    r_lat <= LAT_W'(READ_LAT > 1 ? READ_LAT - 2 : 0);
                end
            end else if (r_state == S_READ) begin
                if (!r_hash_valid) begin
                    if (r_lat == '0) begin
                        r_hash_valid <= 1'b1;
                        r_hash       <= r_digest[511:496];
                    end else begin
                        r_lat <= r_lat - 1'b1;
                    end
                end else if (r_ridx == 5'd31) begin
                    // Readout complete: the next message starts from a clean slate.
                    r_hash_valid <= 1'b0;
                    r_hash       <= '0;
                    r_acc        <= '0;
                    r_ptr        <= '0;
                    r_len        <= '0;
                    r_widx       <= '0;
                    r_first_sent <= 1'b0;
                end else begin
                    r_ridx <= w_ridx_nxt;
                    r_hash <= r_digest[w_hash_base +: 16];
                end
            end
        end
    end

    assign busy       = !((r_state == S_IDLE) || (r_state == S_DIGEST)) || r_core_valid;
    assign core_word  = r_core_word;
    assign core_valid = r_core_valid;
    assign core_first = r_core_first;
    assign core_last  = r_core_last;
    assign hash       = r_hash;
    assign hash_valid = r_hash_valid;

endmodule

// File: tb/tb_omsp_sha512_msg_packer.sv
// tb/tb_omsp_sha512_msg_packer.sv - self-checking bench for omsp_sha512_msg_packer

module tb_omsp_sha512_msg_packer;

    logic         clk = 1'b0;
    logic         rst, core_ready, core_done, data_size;
    logic [1:0]   cmd_in;
    logic [15:0]  data, hash;
    logic         ready_for_data, busy, hash_valid, core_valid, core_first, core_last;
    logic [63:0]  core_word;
    logic [511:0] core_digest;

    always #5 clk = ~clk;

    omsp_sha512_msg_packer dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_in         (cmd_in),
        .data           (data),
`ifdef OMSP_SHA512_BYTE_INPUT_EN
        .data_size      (data_size),
`endif
        .ready_for_data (ready_for_data),
        .busy           (busy),
        .hash           (hash),
        .hash_valid     (hash_valid),
        .core_word      (core_word),
        .core_valid     (core_valid),
        .core_ready     (core_ready),
        .core_first     (core_first),
        .core_last      (core_last),
        .core_digest    (core_digest),
        .core_done      (core_done)
    );

    typedef struct packed {
        logic [63:0] w;
        logic        f;
        logic        l;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] msg[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          word_no = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_word = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%h want=%h", name, got, want);
    endtask

    // Padded message as a byte string, then cut into 64-bit big-endian words.
    task automatic build_exp();
        logic [7:0]   b[$];
        logic [127:0] len;
        logic [63:0]  w;
        exp_t         e;
        int           nw;
        exp_q.delete();
        foreach (msg[i]) begin
            b.push_back(msg[i][15:8]);
            b.push_back(msg[i][7:0]);
        end
        len = {96'd0, 32'(msg.size() * 16)};
        b.push_back(8'h80);
        while ((b.size() % 128) != 112) b.push_back(8'h00);
        for (int i = 15; i >= 0; i--) b.push_back(len[8*i +: 8]);
        nw = b.size() / 8;
        for (int k = 0; k < nw; k++) begin
            w = '0;
            for (int j = 0; j < 8; j++) w = {w[55:0], b[8*k+j]};
            e.w = w;
            e.f = (k == 0);
            e.l = (k == nw - 1);
            exp_q.push_back(e);
        end
        word_no = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst !== 1'b1) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", core_valid, 1);
                chk("hold_word", core_word, prev_word);
            end
            if (core_valid && core_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL extra_word got=%h want=none", core_word);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("core_word[%0d]", word_no), core_word, e.w);
                    chk($sformatf("core_first[%0d]", word_no), core_first, e.f);
                    chk($sformatf("core_last[%0d]", word_no), core_last, e.l);
                end
                word_no++;
            end
            prev_stall = core_valid && !core_ready;
            prev_word  = core_word;
        end
    end

    task automatic send_half(input logic [15:0] h);
        int n = 0;
        cmd_in = 2'b10;
        data   = h;
        @(negedge clk);
        while (!ready_for_data && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_total++;
            $display("FAIL send_timeout got=ready_low want=accept");
        end
        @(posedge clk); #1;
        cmd_in = 2'b00;
    endtask

    task automatic finalize();
        cmd_in = 2'b11;
        @(posedge clk); #1;
        cmd_in = 2'b00;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain_timeout got=%0d words left want=0", exp_q.size());
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        msg.delete();
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b0; cmd_in = 2'b00; data = '0; data_size = 1'b1;
        core_ready = 1'b1; core_done = 1'b0; core_digest = '0;
        @(posedge clk); #1;
        chk("rst_ready", ready_for_data, 1);
        chk("rst_busy", busy, 0);
        chk("rst_hash", hash, 0);
        chk("rst_hash_valid", hash_valid, 0);
        chk("rst_core_valid", core_valid, 0);
        chk("rst_core_first", core_first, 0);
        chk("rst_core_last", core_last, 0);
        chk("rst_core_word", core_word, 0);
        rst = 1'b1;

        // Empty message, then digest readout.
        msg.delete();
        build_exp();
        chk("model_empty_size", exp_q.size(), 16);
        chk("model_empty_w0", exp_q[0].w, 64'h8000_0000_0000_0000);
        chk("model_empty_w15", exp_q[15].w, 64'h0);
        finalize();
        wait_done();
        @(negedge clk);
        chk("wait_busy", busy, 1);
        chk("wait_ready", ready_for_data, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) core_digest[511-16*i -: 16] = 16'(i);
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        core_digest = '1;
        @(negedge clk);
        chk("digest_busy", busy, 0);
        chk("digest_ready", ready_for_data, 0);
        @(posedge clk); #1;
        cmd_in = 2'b01;
        @(posedge clk); #1;
        cmd_in = 2'b00;
        @(negedge clk);
        chk("read_lat_valid", hash_valid, 0);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk($sformatf("hash_valid[%0d]", i), hash_valid, 1);
            chk($sformatf("hash[%0d]", i), hash, 64'(i));
        end
        @(negedge clk);
        chk("read_end_valid", hash_valid, 0);
        chk("read_end_ready", ready_for_data, 1);
        chk("read_end_busy", busy, 0);

        // core_done and readout commands while idle are ignored.
        @(posedge clk); #1;
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        cmd_in = 2'b01;
        @(posedge clk); #1;
        cmd_in = 2'b00;
        @(negedge clk);
        chk("idle_done_ready", ready_for_data, 1);
        chk("idle_done_busy", busy, 0);
        @(negedge clk);
        chk("idle_cmd01_valid", hash_valid, 0);
        @(posedge clk); #1;

        // One halfword after a completed readout (length must restart at zero).
        msg.delete();
        msg.push_back(16'h6162);
        build_exp();
        chk("model_6162_w0", exp_q[0].w, 64'h6162_8000_0000_0000);
        chk("model_6162_w15", exp_q[15].w, 64'h10);
        send_half(16'h6162);
        finalize();
        wait_done();
        do_reset();

        // 896-bit message forces a second block.
        for (int i = 0; i < 56; i++) msg.push_back(16'hAAAA);
        build_exp();
        chk("model_896_size", exp_q.size(), 32);
        chk("model_896_w14", exp_q[14].w, 64'h8000_0000_0000_0000);
        chk("model_896_w31", exp_q[31].w, 64'h380);
        chk("model_896_l31", exp_q[31].l, 1);
        for (int i = 0; i < 56; i++) send_half(16'hAAAA);
        finalize();
        wait_done();
        do_reset();

        // Backpressure: 8th halfword must be refused until the core drains.
        for (int i = 1; i <= 8; i++) msg.push_back(16'(i));
        build_exp();
        chk("model_bp_w0", exp_q[0].w, 64'h0001_0002_0003_0004);
        chk("model_bp_w15", exp_q[15].w, 64'h80);
        core_ready = 1'b0;
        for (int i = 1; i <= 7; i++) send_half(16'(i));
        cmd_in = 2'b10;
        data = 16'd8;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready_low", ready_for_data, 0);
            chk("bp_core_valid", core_valid, 1);
        end
        @(posedge clk); #1;
        core_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_release", ready_for_data, 1);
        @(posedge clk); #1;
        cmd_in = 2'b00;
        finalize();
        wait_done();
        do_reset();

        // Reset while emitting zero words, then a clean message.
        msg.push_back(16'h6162);
        build_exp();
        send_half(16'h6162);
        finalize();
        n = 0;
        while (exp_q.size() > 12 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_progress", (exp_q.size() <= 12), 1);
        do_reset();
        @(negedge clk);
        chk("abort_core_valid", core_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", ready_for_data, 1);
        @(posedge clk); #1;
        msg.push_back(16'h6162);
        build_exp();
        send_half(16'h6162);
        finalize();
        wait_done();
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
